dfu_ip_pingpong_ctrl: RTL and testbench

- Ping-pong controller for the DFU input SRAM banks A and B.
- Tells the load FSM which bank to fill next and tracks per-bank full/empty state plus fill length.
- When the operand side requests a tile, sweeps read enables and addresses across all SRAM lanes of the full bank, then frees the bank.
- Sits between dfu_ip_fsm (write side), sram_banks (read ports) and the operand consumer.

---
 rtl/dfu_ip_pingpong_ctrl.sv | 134 +++++++++++++
 tb/tb_dfu_ip_pingpong_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dfu_ip_pingpong_ctrl.sv
// Ping-pong controller for the DFU input SRAM banks A/B: tracks fill state
// per bank and sweeps read enables/addresses over a full bank for the consumer.
module dfu_ip_pingpong_ctrl #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned SRAM_ADDR = 10,
  parameter int unsigned LEN_W     = SRAM_ADDR + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fill_done,
  input  logic [LEN_W-1:0]               fill_len,
  output logic                           wr_bank_sel,
  output logic                           wr_allow,
  input  logic                           op2dfu_rd_req,
  input  logic                           op2dfu_stall,
  output logic                           dfu2op_rd_busy,
  output logic                           dfu2op_tile_done,
  output logic                           dfu2op_tile_bank,
  output logic [NUM_LANES-1:0]           dfu2ip_a_sram_rd_en,
  output logic [NUM_LANES*SRAM_ADDR-1:0] dfu2ip_a_sram_rd_addr,
  output logic [NUM_LANES-1:0]           dfu2ip_b_sram_rd_en,
  output logic [NUM_LANES*SRAM_ADDR-1:0] dfu2ip_b_sram_rd_addr,
  output logic [1:0]                     bank_full,
  output logic                           proto_err
);

  localparam int unsigned CNT_W = SRAM_ADDR + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << SRAM_ADDR;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic                 wr_sel_q;
  logic [1:0]           full_q, full_d;
  logic [LEN_W-1:0]     len_q [2];
  logic                 rd_ptr_q;
  logic [CNT_W-1:0]     addr_q;
  logic                 tile_bank_q;
  logic                 tile_done_q;
  logic                 rd_en_q;
  logic [SRAM_ADDR-1:0] rd_addr_q;
  logic                 perr_q;

  logic                 fill_valid, fill_ok, len_over;
  logic [LEN_W-1:0]     fill_len_c;
  logic                 start, issue, last;

  assign wr_allow   = ~full_q[wr_sel_q];
  assign fill_valid = fill_done && (fill_len != '0);
  assign fill_ok    = fill_valid && wr_allow;
  assign len_over   = fill_len > MAX_LEN;
  assign fill_len_c = len_over ? MAX_LEN : fill_len;

  assign start = (state_q == IDLE) && op2dfu_rd_req && full_q[rd_ptr_q];
  assign issue = (state_q == READ) && !op2dfu_stall;
  assign last  = issue && (addr_q == CNT_W'(len_q[tile_bank_q] - LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (last)  state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Freeing one bank and filling the other can land in the same cycle; the
  // freed bank itself cannot be refilled here because wr_allow is still low.
  always_comb begin
    full_d = full_q;
    if (state_q == DRAIN) full_d[tile_bank_q] = 1'b0;
    if (fill_ok)          full_d[wr_sel_q]    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel_q    <= 1'b0;
      full_q      <= '0;
      len_q[0]    <= '0;
      len_q[1]    <= '0;
      rd_ptr_q    <= 1'b0;
      addr_q      <= '0;
      tile_bank_q <= 1'b0;
      tile_done_q <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      perr_q      <= 1'b0;
    end else begin
      full_q <= full_d;
      if (fill_ok) begin
        len_q[wr_sel_q] <= fill_len_c;
        wr_sel_q        <= ~wr_sel_q;
      end
      if (fill_valid && (!wr_allow || len_over)) perr_q <= 1'b1;

      if (start) begin
        addr_q      <= '0;
        tile_bank_q <= rd_ptr_q;
      end
      rd_en_q <= issue;
      if (issue) begin
        rd_addr_q <= addr_q[SRAM_ADDR-1:0];
        addr_q    <= addr_q + CNT_W'(1);
      end

      // DRAIN covers the one-cycle SRAM read latency of the final address
      tile_done_q <= (state_q == DRAIN);
      if (state_q == DRAIN) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign wr_bank_sel      = wr_sel_q;
  assign bank_full        = full_q;
  assign proto_err        = perr_q;
  assign dfu2op_rd_busy   = (state_q != IDLE);
  assign dfu2op_tile_done = tile_done_q;
  assign dfu2op_tile_bank = tile_bank_q;

  assign dfu2ip_a_sram_rd_en   = {NUM_LANES{rd_en_q & ~tile_bank_q}};
  assign dfu2ip_b_sram_rd_en   = {NUM_LANES{rd_en_q &  tile_bank_q}};
  assign dfu2ip_a_sram_rd_addr = tile_bank_q ? '0 : {NUM_LANES{rd_addr_q}};
  assign dfu2ip_b_sram_rd_addr = tile_bank_q ? {NUM_LANES{rd_addr_q}} : '0;

endmodule

// File: tb/tb_dfu_ip_pingpong_ctrl.sv
// Directed table-driven bench for dfu_ip_pingpong_ctrl plus a full-depth sweep.
module tb_dfu_ip_pingpong_ctrl;

  localparam int unsigned NL = 4;
  localparam int unsigned SA = 10;
  localparam int unsigned LW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, fill_done, op2dfu_rd_req, op2dfu_stall;
  logic [LW-1:0]    fill_len;
  logic             wr_bank_sel, wr_allow, rd_busy, tile_done, tile_bank, proto_err;
  logic [NL-1:0]    a_en, b_en;
  logic [NL*SA-1:0] a_addr, b_addr;
  logic [1:0]       bank_full;

  dfu_ip_pingpong_ctrl #(.NUM_LANES(NL), .SRAM_ADDR(SA), .LEN_W(LW)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .fill_done             (fill_done),
    .fill_len              (fill_len),
    .wr_bank_sel           (wr_bank_sel),
    .wr_allow              (wr_allow),
    .op2dfu_rd_req         (op2dfu_rd_req),
    .op2dfu_stall          (op2dfu_stall),
    .dfu2op_rd_busy        (rd_busy),
    .dfu2op_tile_done      (tile_done),
    .dfu2op_tile_bank      (tile_bank),
    .dfu2ip_a_sram_rd_en   (a_en),
    .dfu2ip_a_sram_rd_addr (a_addr),
    .dfu2ip_b_sram_rd_en   (b_en),
    .dfu2ip_b_sram_rd_addr (b_addr),
    .bank_full             (bank_full),
    .proto_err             (proto_err)
  );

  typedef struct {
    logic          rst, fd;
    logic [LW-1:0] len;
    logic          req, stl;
    logic          wsel, alw;
    logic [1:0]    full;
    logic          busy, td, tb, aen, ben;
    logic [SA-1:0] addr;
    logic          perr;
  } vec_t;

  vec_t vq[$];
  int unsigned n_vec = 0;
  int unsigned n_miss = 0;

  function automatic vec_t mk(input logic r, fd, input int len, input logic req, stl,
                              input logic wsel, alw, input logic [1:0] full,
                              input logic busy, td, tb, aen, ben, input int addr,
                              input logic perr);
    vec_t v;
    v.rst = r; v.fd = fd; v.len = LW'(len); v.req = req; v.stl = stl;
    v.wsel = wsel; v.alw = alw; v.full = full; v.busy = busy; v.td = td;
    v.tb = tb; v.aen = aen; v.ben = ben; v.addr = SA'(addr); v.perr = perr;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    logic [NL*SA-1:0] ea;
    int cnt, bad, seen, prev_en;

    rst = 1'b1; fill_done = 1'b0; fill_len = '0; op2dfu_rd_req = 1'b0; op2dfu_stall = 1'b0;

    // T1: single len-8 tile on A
    vq.push_back(mk(1,0,0,0,0, 0,1,2'b00,0,0,0,0,0,0,0));
    vq.push_back(mk(0,1,8,0,0, 1,1,2'b01,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,1,0, 1,1,2'b01,1,0,0,0,0,0,0));
    for (int k = 0; k < 8; k++) vq.push_back(mk(0,0,0,1,0, 1,1,2'b01,1,0,0,1,0,k,0));
    vq.push_back(mk(0,0,0,1,0, 1,1,2'b00,0,1,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 1,1,2'b00,0,0,0,0,0,0,0));
    // T2: back-to-back A(4) then B(3)
    vq.push_back(mk(1,0,0,0,0, 0,1,2'b00,0,0,0,0,0,0,0));
    vq.push_back(mk(0,1,4,0,0, 1,1,2'b01,0,0,0,0,0,0,0));
    vq.push_back(mk(0,1,3,0,0, 0,0,2'b11,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,1,0, 0,0,2'b11,1,0,0,0,0,0,0));
    for (int k = 0; k < 4; k++) vq.push_back(mk(0,0,0,1,0, 0,0,2'b11,1,0,0,1,0,k,0));
    vq.push_back(mk(0,0,0,1,0, 0,1,2'b10,0,1,0,0,0,0,0));
    vq.push_back(mk(0,0,0,1,0, 0,1,2'b10,1,0,1,0,0,0,0));
    for (int k = 0; k < 3; k++) vq.push_back(mk(0,0,0,1,0, 0,1,2'b10,1,0,1,0,1,k,0));
    vq.push_back(mk(0,0,0,0,0, 0,1,2'b00,0,1,1,0,0,0,0));
    // T3: len-5 tile with two stall cycles after addr 2
    vq.push_back(mk(1,0,0,0,0, 0,1,2'b00,0,0,0,0,0,0,0));
    vq.push_back(mk(0,1,5,0,0, 1,1,2'b01,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,1,0, 1,1,2'b01,1,0,0,0,0,0,0));
    for (int k = 0; k < 3; k++) vq.push_back(mk(0,0,0,1,0, 1,1,2'b01,1,0,0,1,0,k,0));
    vq.push_back(mk(0,0,0,1,1, 1,1,2'b01,1,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,1,1, 1,1,2'b01,1,0,0,0,0,0,0));
    for (int k = 3; k < 5; k++) vq.push_back(mk(0,0,0,1,0, 1,1,2'b01,1,0,0,1,0,k,0));
    vq.push_back(mk(0,0,0,0,0, 1,1,2'b00,0,1,0,0,0,0,0));
    // T4: zero-length fill ignored, overfill flags proto_err
    vq.push_back(mk(1,0,0,0,0, 0,1,2'b00,0,0,0,0,0,0,0));
    vq.push_back(mk(0,1,0,0,0, 0,1,2'b00,0,0,0,0,0,0,0));
    vq.push_back(mk(0,1,2,0,0, 1,1,2'b01,0,0,0,0,0,0,0));
    vq.push_back(mk(0,1,2,0,0, 0,0,2'b11,0,0,0,0,0,0,0));
    vq.push_back(mk(0,1,5,0,0, 0,0,2'b11,0,0,0,0,0,0,1));
    vq.push_back(mk(0,1,0,0,0, 0,0,2'b11,0,0,0,0,0,0,1));
    // T5: fill B in the DRAIN cycle that frees A
    vq.push_back(mk(1,0,0,0,0, 0,1,2'b00,0,0,0,0,0,0,0));
    vq.push_back(mk(0,1,2,0,0, 1,1,2'b01,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,1,0, 1,1,2'b01,1,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,1,0, 1,1,2'b01,1,0,0,1,0,0,0));
    vq.push_back(mk(0,0,0,1,0, 1,1,2'b01,1,0,0,1,0,1,0));
    vq.push_back(mk(0,1,3,0,0, 0,1,2'b10,0,1,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 0,1,2'b10,0,0,0,0,0,0,0));
    // T6: reset in the middle of a len-16 sweep
    vq.push_back(mk(1,0,0,0,0, 0,1,2'b00,0,0,0,0,0,0,0));
    vq.push_back(mk(0,1,16,0,0, 1,1,2'b01,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,1,0, 1,1,2'b01,1,0,0,0,0,0,0));
    for (int k = 0; k < 6; k++) vq.push_back(mk(0,0,0,1,0, 1,1,2'b01,1,0,0,1,0,k,0));
    vq.push_back(mk(1,0,0,1,0, 0,1,2'b00,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,1,0, 0,1,2'b00,0,0,0,0,0,0,0));

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; fill_done = vq[i].fd; fill_len = vq[i].len;
      op2dfu_rd_req = vq[i].req; op2dfu_stall = vq[i].stl;
      @(posedge clk); #1;
      chk("wr_bank_sel", i, 64'(wr_bank_sel), 64'(vq[i].wsel));
      chk("wr_allow",    i, 64'(wr_allow),    64'(vq[i].alw));
      chk("bank_full",   i, 64'(bank_full),   64'(vq[i].full));
      chk("rd_busy",     i, 64'(rd_busy),     64'(vq[i].busy));
      chk("tile_done",   i, 64'(tile_done),   64'(vq[i].td));
      chk("tile_bank",   i, 64'(tile_bank),   64'(vq[i].tb));
      chk("proto_err",   i, 64'(proto_err),   64'(vq[i].perr));
      chk("a_rd_en",     i, 64'(a_en), 64'({NL{vq[i].aen}}));
      chk("b_rd_en",     i, 64'(b_en), 64'({NL{vq[i].ben}}));
      ea = {NL{vq[i].addr}};
      if (vq[i].aen) chk("a_rd_addr", i, 64'(a_addr), 64'(ea));
      if (vq[i].ben) chk("b_rd_addr", i, 64'(b_addr), 64'(ea));
    end

    // Reset clears addresses; oversize fill clamps to full depth and sweeps without wrap
    rst = 1'b1; fill_done = 1'b0; op2dfu_rd_req = 1'b0; op2dfu_stall = 1'b0;
    @(posedge clk); #1;
    chk("rst_a_addr", 0, 64'(a_addr), 64'd0);
    chk("rst_b_addr", 0, 64'(b_addr), 64'd0);
    rst = 1'b0; fill_done = 1'b1; fill_len = LW'(2000);
    @(posedge clk); #1;
    fill_done = 1'b0; fill_len = '0;
    chk("clamp_perr", 0, 64'(proto_err), 64'd1);
    chk("clamp_full", 0, 64'(bank_full), 64'd1);
    op2dfu_rd_req = 1'b1;
    cnt = 0; bad = 0; seen = 0; prev_en = 0;
    for (int c = 0; c < 1100 && seen == 0; c++) begin
      @(posedge clk); #1;
      if (tile_done) begin
        seen = 1;
        chk("sweep_done_gap", c, 64'(prev_en), 64'd1);
      end
      prev_en = (a_en == '1) ? 1 : 0;
      if (a_en == '1) begin
        ea = {NL{SA'(cnt)}};
        if (a_addr !== ea) bad++;
        cnt++;
      end else if (a_en != '0) bad++;
      if (b_en != '0) bad++;
    end
    op2dfu_rd_req = 1'b0;
    chk("sweep_seen_done", 0, 64'(seen), 64'd1);
    chk("sweep_len",  0, 64'(cnt), 64'd1024);
    chk("sweep_addr", 0, 64'(bad), 64'd0);
    chk("sweep_free", 0, 64'(bank_full), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
